// File: rtl/priv_mode_ctrl_pkg.sv
// Shared types and constants for the M/U privilege-mode and trap controller.
package priv_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_M = 2'b11
    } priv_lvl_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_RET   = 2'd2,
        ST_SLEEP = 2'd3
    } ctrl_state_e;

    localparam int unsigned EXC_ILLEGAL = 32'd2;
    localparam int unsigned EXC_ECALL_U = 32'd8;
    localparam int unsigned EXC_ECALL_M = 32'd11;

    // Clear the low alignment bits of an address.
    function automatic logic [31:0] align_down(input logic [31:0] addr, input int unsigned lsbs);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << lsbs;
        return addr & mask;
    endfunction

endpackage

// File: rtl/priv_mode_ctrl_if.sv
// Retiring-instruction handshake between the decoder and priv_mode_ctrl.
interface priv_mode_ctrl_if #(
    parameter int XLEN = 32
);
    logic            insn_valid_i;
    logic            insn_ready_o;
    logic [XLEN-1:0] insn_pc_i;
    logic [31:0]     insn_word_i;
    logic            mret_insn_i;
    logic            wfi_insn_i;
    logic            ecall_insn_i;
    logic            illegal_insn_i;

    modport master (
        output insn_valid_i, insn_pc_i, insn_word_i,
               mret_insn_i, wfi_insn_i, ecall_insn_i, illegal_insn_i,
        input  insn_ready_o
    );

    modport slave (
        input  insn_valid_i, insn_pc_i, insn_word_i,
               mret_insn_i, wfi_insn_i, ecall_insn_i, illegal_insn_i,
        output insn_ready_o
    );
endinterface

// File: rtl/priv_mode_ctrl_trap_decode.sv
// priv_trap_decode: purely combinational classification of one retiring
// instruction into trap / return / sleep / retire, with the trap cause.
module priv_trap_decode
    import priv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IRQ_CODE = 11
) (
    input  priv_lvl_e        priv_i,
    input  logic             mie_i,
    input  logic             tw_i,
    input  logic             irq_i,
    input  logic             mret_i,
    input  logic             wfi_i,
    input  logic             ecall_i,
    input  logic             illegal_i,
    output logic             illegal_umode_o,
    output logic             int_take_o,
    output logic             tval_insn_o,
    output logic [XLEN-1:0]  cause_o,
    output ctrl_state_e      state_req_o
);
    logic w_illegal_umode;
    logic w_int_take;

    assign w_illegal_umode = (priv_i != PRIV_LVL_M) & (mret_i | (tw_i & wfi_i));
    // U-mode is always interruptible; M-mode only with MIE set.
    assign w_int_take      = irq_i & (mie_i | (priv_i == PRIV_LVL_U));

    assign illegal_umode_o = w_illegal_umode;
    assign int_take_o      = w_int_take;

    // Priority classification of the presented instruction.
    always_comb begin
        state_req_o = ST_IDLE;
        cause_o     = {XLEN{1'b0}};
        tval_insn_o = 1'b0;
        if (w_int_take) begin
            state_req_o = ST_TRAP;
            cause_o     = {1'b1, (XLEN-1)'(IRQ_CODE)};
        end else if (illegal_i | w_illegal_umode) begin
            state_req_o = ST_TRAP;
            cause_o     = XLEN'(EXC_ILLEGAL);
            tval_insn_o = 1'b1;
        end else if (ecall_i) begin
            state_req_o = ST_TRAP;
            if (priv_i == PRIV_LVL_U) begin
                cause_o = XLEN'(EXC_ECALL_U);
            end else begin
                cause_o = XLEN'(EXC_ECALL_M);
            end
        end else if (mret_i) begin
            state_req_o = ST_RET;
        end else if (wfi_i) begin
            // A pending interrupt makes WFI retire as a no-op.
            if (irq_i) begin
                state_req_o = ST_IDLE;
            end else begin
                state_req_o = ST_SLEEP;
            end
        end else begin
            state_req_o = ST_IDLE;
        end
    end

endmodule

// File: rtl/priv_mode_ctrl.sv
// priv_mode_ctrl: privilege level, machine trap CSRs, trap entry, MRET and WFI.
// Optional build macro PRIV_MTVAL_EN adds the mtval register.
module priv_mode_ctrl
    import priv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IRQ_CODE = 11
) (
    input  logic                clk_i,
    input  logic                rst_i,
    priv_mode_ctrl_if.slave     bus,
    input  logic                csr_mstatus_tw_i,
    input  logic                irq_pending_i,
    input  logic [XLEN-1:0]     mtvec_i,
    output logic [1:0]          priv_mode_o,
    output logic                mstatus_mie_o,
    output logic                mstatus_mpie_o,
    output logic [1:0]          mstatus_mpp_o,
    output logic [XLEN-1:0]     mepc_o,
    output logic [XLEN-1:0]     mcause_o,
    output logic [XLEN-1:0]     mtval_o,
    output logic                pc_set_o,
    output logic [XLEN-1:0]     pc_target_o,
    output logic                flush_o,
    output logic                sleep_o
);
    ctrl_state_e     r_state;
    ctrl_state_e     w_state_nxt;
    ctrl_state_e     w_state_req;
    priv_lvl_e       r_priv;
    priv_lvl_e       r_mpp;
    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mepc_cand;
    logic [XLEN-1:0] r_cause_cand;
    logic [XLEN-1:0] r_pc_target;
    logic [XLEN-1:0] w_cause;
    logic            w_accept;
    logic            w_illegal_umode;
    logic            w_int_take;
    logic            w_tval_insn;

    assign bus.insn_ready_o = (r_state == ST_IDLE);
    assign w_accept         = bus.insn_valid_i & bus.insn_ready_o;

    priv_trap_decode #(
        .XLEN     (XLEN),
        .IRQ_CODE (IRQ_CODE)
    ) u_decode (
        .priv_i          (r_priv),
        .mie_i           (r_mie),
        .tw_i            (csr_mstatus_tw_i),
        .irq_i           (irq_pending_i),
        .mret_i          (bus.mret_insn_i),
        .wfi_i           (bus.wfi_insn_i),
        .ecall_i         (bus.ecall_insn_i),
        .illegal_i       (bus.illegal_insn_i),
        .illegal_umode_o (w_illegal_umode),
        .int_take_o      (w_int_take),
        .tval_insn_o     (w_tval_insn),
        .cause_o         (w_cause),
        .state_req_o     (w_state_req)
    );

    // Controller next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_state_req;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TRAP:  w_state_nxt = ST_IDLE;
            ST_RET:   w_state_nxt = ST_IDLE;
            ST_SLEEP: begin
                // Wake on any pending interrupt, independent of MIE.
                if (irq_pending_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SLEEP;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture trap candidates and the redirect target at acceptance, so no
    // input reaches an output combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mepc_cand  <= {XLEN{1'b0}};
            r_cause_cand <= {XLEN{1'b0}};
            r_pc_target  <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_mepc_cand  <= {bus.insn_pc_i[XLEN-1:1], 1'b0};
            r_cause_cand <= w_cause;
            if (w_state_req == ST_TRAP) begin
                r_pc_target <= {mtvec_i[XLEN-1:2], 2'b00};
            end else if (w_state_req == ST_RET) begin
                r_pc_target <= r_mepc;
            end else begin
                r_pc_target <= r_pc_target;
            end
        end else begin
            r_mepc_cand  <= r_mepc_cand;
            r_cause_cand <= r_cause_cand;
            r_pc_target  <= r_pc_target;
        end
    end

    // Privilege and mstatus/mepc/mcause update at the close of TRAP or RET.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_priv   <= PRIV_LVL_M;
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mpp    <= PRIV_LVL_U;
            r_mepc   <= {XLEN{1'b0}};
            r_mcause <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                ST_TRAP: begin
                    r_mpp    <= r_priv;
                    r_mpie   <= r_mie;
                    r_mie    <= 1'b0;
                    r_priv   <= PRIV_LVL_M;
                    r_mepc   <= r_mepc_cand;
                    r_mcause <= r_cause_cand;
                end
                ST_RET: begin
                    r_priv   <= r_mpp;
                    r_mie    <= r_mpie;
                    r_mpie   <= 1'b1;
                    r_mpp    <= PRIV_LVL_U;
                end
                default: begin
                    r_priv   <= r_priv;
                    r_mie    <= r_mie;
                    r_mpie   <= r_mpie;
                    r_mpp    <= r_mpp;
                    r_mepc   <= r_mepc;
                    r_mcause <= r_mcause;
                end
            endcase
        end
    end

`ifdef PRIV_MTVAL_EN
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_mtval_cand;

    // mtval candidate: faulting word for illegal-instruction traps, else zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mtval_cand <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_mtval_cand <= w_tval_insn ? XLEN'(bus.insn_word_i) : {XLEN{1'b0}};
        end else begin
            r_mtval_cand <= r_mtval_cand;
        end
    end

    // mtval register, written together with mcause.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mtval <= {XLEN{1'b0}};
        end else if (r_state == ST_TRAP) begin
            r_mtval <= r_mtval_cand;
        end else begin
            r_mtval <= r_mtval;
        end
    end

    assign mtval_o = r_mtval;

    logic w_unused;
    assign w_unused = &{1'b0, mtvec_i[1:0], bus.insn_pc_i[0], w_illegal_umode, w_int_take};
`else
    assign mtval_o = {XLEN{1'b0}};

    logic w_unused;
    assign w_unused = &{1'b0, mtvec_i[1:0], bus.insn_pc_i[0], w_illegal_umode, w_int_take,
                        w_tval_insn, bus.insn_word_i};
`endif

    assign priv_mode_o    = r_priv;
    assign mstatus_mie_o  = r_mie;
    assign mstatus_mpie_o = r_mpie;
    assign mstatus_mpp_o  = r_mpp;
    assign mepc_o         = r_mepc;
    assign mcause_o       = r_mcause;
    assign pc_set_o       = (r_state == ST_TRAP) | (r_state == ST_RET);
    assign flush_o        = (r_state == ST_TRAP) | (r_state == ST_RET);
    assign pc_target_o    = r_pc_target;
    assign sleep_o        = (r_state == ST_SLEEP);

endmodule
